// File: rtl/ex_div.sv
// Radix-2 restoring DIV/DIVU for EX; returns {remainder, quotient} and holds EX via stallreq_o until ready.
// Latency DATA_W+1 cycles (2 on divide-by-zero; 1 when DIV_EARLY_OUT_EN is defined and |divisor| > |dividend|).
module ex_div #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o,
    output logic                stallreq_o
);
    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [2*DATA_W:0]   work;
    logic [2*DATA_W:0]   work_nxt;
    logic [DATA_W-1:0]   divisor;
    logic                neg_q;
    logic                neg_r;
    logic [DATA_W:0]     diff;
    logic [DATA_W-1:0]   a_abs;
    logic [DATA_W-1:0]   b_abs;
    logic [DATA_W-1:0]   quo;
    logic [DATA_W-1:0]   rem;
    logic                early;

    assign a_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign b_abs = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

`ifdef DIV_EARLY_OUT_EN
    assign early = (b_abs > a_abs);
`else
    assign early = 1'b0;
`endif

    // Partial remainder sits in work[2W:W+1]; a failed trial subtract leaves bit W set in diff.
    assign diff     = work[2*DATA_W:DATA_W] - {1'b0, divisor};
    assign work_nxt = diff[DATA_W] ? {work[2*DATA_W-1:0], 1'b0}
                                   : {diff[DATA_W-1:0], work[DATA_W-1:0], 1'b1};
    assign quo = neg_q ? -work_nxt[DATA_W-1:0] : work_nxt[DATA_W-1:0];
    assign rem = neg_r ? -work_nxt[2*DATA_W:DATA_W+1] : work_nxt[2*DATA_W:DATA_W+1];

    assign stallreq_o = start_i & ~ready_o;

    always_ff @(posedge clk) begin
        if (resetn) begin
            state    <= FREE;
            cnt      <= '0;
            work     <= '0;
            divisor  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state <= BYZERO;
                        end else if (early) begin
                            result_o <= {opdata1_i, {DATA_W{1'b0}}};
                            ready_o  <= 1'b1;
                            state    <= END;
                        end else begin
                            work    <= {{DATA_W{1'b0}}, a_abs, 1'b0};
                            divisor <= b_abs;
                            neg_r   <= signed_div_i & opdata1_i[DATA_W-1];
                            neg_q   <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                            cnt     <= '0;
                            state   <= ON;
                        end
                    end
                end
                BYZERO: begin
                    if (annul_i) begin
                        state <= FREE;
                    end else begin
                        result_o <= '0;
                        ready_o  <= 1'b1;
                        state    <= END;
                    end
                end
                ON: begin
                    if (annul_i) begin
                        cnt   <= '0;
                        state <= FREE;
                    end else begin
                        work <= work_nxt;
                        cnt  <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(DATA_W-1)) begin
                            result_o <= {rem, quo};
                            ready_o  <= 1'b1;
                            state    <= END;
                        end
                    end
                end
                END: begin
                    if (!start_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                        state    <= FREE;
                    end
                end
                default: state <= FREE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_div.sv
// Randomized and directed bench for ex_div against a plain-arithmetic division model.
module tb_ex_div;
    logic        clk;
    logic        resetn;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        stallreq;

    int checks = 0;
    int errors = 0;

    ex_div #(.DATA_W(32), .CNT_W(6)) dut (
        .clk(clk), .resetn(resetn), .signed_div_i(signed_div),
        .opdata1_i(opdata1), .opdata2_i(opdata2), .start_i(start),
        .annul_i(annul), .result_o(result), .ready_o(ready), .stallreq_o(stallreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    function automatic int exp_lat(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint ma, mb;
        if (b == 32'd0) return 2;
        ma = sgn ? $signed(a) : longint'(a);
        mb = sgn ? $signed(b) : longint'(b);
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
`ifdef DIV_EARLY_OUT_EN
        if (mb > ma) return 1;
`endif
        return 33;
    endfunction

    // Drives one operation with start held until ready, holds one extra cycle, then drops start.
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int stall_cnt, output logic [63:0] res,
                          output logic [63:0] res_hold, output logic [63:0] res_after,
                          output logic rdy_after);
        lat = -1;
        stall_cnt = 0;
        res = '0;
        @(negedge clk);
        signed_div = sgn; opdata1 = a; opdata2 = b; start = 1'b1;
        #1;
        if (stallreq) stall_cnt++;
        for (int n = 1; n <= 60 && lat < 0; n++) begin
            @(negedge clk);
            opdata1 = $urandom;
            opdata2 = $urandom;
            if (ready) begin
                lat = n;
                res = result;
            end else if (stallreq) begin
                stall_cnt++;
            end
        end
        @(negedge clk);
        res_hold = result;
        start = 1'b0;
        @(negedge clk);
        res_after = result;
        rdy_after = ready;
    endtask

    task automatic test_reset();
        resetn = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
        opdata1 = '0; opdata2 = '0;
        repeat (3) @(negedge clk);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", ready); end
        checks++; if (result !== 64'd0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
        checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL reset_stall_idle got %0b want 0", stallreq); end
        start = 1'b1;
        #1;
        checks++; if (stallreq !== 1'b1) begin errors++; $display("FAIL reset_stall_start got %0b want 1", stallreq); end
        start = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
    endtask

    task automatic test_basic();
        int lat, sc; logic [63:0] r, rh, ra; logic rd;
        run_op(1'b0, 32'd100, 32'd7, lat, sc, r, rh, ra, rd);
        checks++; if (lat !== 33) begin errors++; $display("FAIL divu100_7_latency got %0d want 33", lat); end
        checks++; if (r !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu100_7_result got %h want %h", r, {32'd2, 32'd14}); end
        checks++; if (sc !== 33) begin errors++; $display("FAIL divu100_7_stall_cycles got %0d want 33", sc); end
        checks++; if (rh !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu100_7_hold got %h want %h", rh, {32'd2, 32'd14}); end
        checks++; if (rd !== 1'b0 || ra !== 64'd0) begin errors++; $display("FAIL divu100_7_clear got rdy=%0b res=%h want 0/0", rd, ra); end
    endtask

    task automatic test_signed();
        int lat, sc; logic [63:0] r, rh, ra; logic rd;
        logic [31:0] as [4] = '{32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9, 32'h8000_0000};
        logic [31:0] bs [4] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [63:0] ex [4] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'd1, 32'hFFFF_FFFD},
                                {32'hFFFF_FFFF, 32'd3}, {32'd0, 32'h8000_0000}};
        for (int i = 0; i < 4; i++) begin
            run_op(1'b1, as[i], bs[i], lat, sc, r, rh, ra, rd);
            checks++; if (r !== ex[i]) begin errors++; $display("FAIL div_signed_%0d got %h want %h", i, r, ex[i]); end
            checks++; if (lat !== exp_lat(1'b1, as[i], bs[i])) begin errors++; $display("FAIL div_signed_lat_%0d got %0d want %0d", i, lat, exp_lat(1'b1, as[i], bs[i])); end
        end
    endtask

    task automatic test_div_zero();
        int lat, sc; logic [63:0] r, rh, ra; logic rd;
        run_op(1'b0, 32'd5, 32'd0, lat, sc, r, rh, ra, rd);
        checks++; if (lat !== 2) begin errors++; $display("FAIL divu_zero_latency got %0d want 2", lat); end
        checks++; if (r !== 64'd0) begin errors++; $display("FAIL divu_zero_result got %h want 0", r); end
        checks++; if (sc !== 2) begin errors++; $display("FAIL divu_zero_stall got %0d want 2", sc); end
        run_op(1'b1, 32'hFFFF_FFFB, 32'd0, lat, sc, r, rh, ra, rd);
        checks++; if (lat !== 2 || r !== 64'd0) begin errors++; $display("FAIL div_zero_signed got lat=%0d res=%h want 2/0", lat, r); end
    endtask

    task automatic test_annul();
        int rdy_cnt, lat, sc; logic [63:0] r, rh, ra; logic rd;
        @(negedge clk);
        signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3; start = 1'b1;
        repeat (10) @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0; start = 1'b0;
        rdy_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready) rdy_cnt++;
        end
        checks++; if (rdy_cnt !== 0) begin errors++; $display("FAIL annul_ready got %0d ready cycles want 0", rdy_cnt); end
        run_op(1'b0, 32'd9, 32'd3, lat, sc, r, rh, ra, rd);
        checks++; if (lat !== 33) begin errors++; $display("FAIL after_annul_latency got %0d want 33", lat); end
        checks++; if (r !== {32'd0, 32'd3}) begin errors++; $display("FAIL after_annul_result got %h want %h", r, {32'd0, 32'd3}); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [63:0] r;
        @(negedge clk);
        signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd7; start = 1'b1;
        repeat (20) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checks++; if (ready !== 1'b0 || result !== 64'd0) begin errors++; $display("FAIL midreset_outputs got rdy=%0b res=%h want 0/0", ready, result); end
        resetn = 1'b0;
        lat = -1; r = '0;
        for (int n = 1; n <= 60 && lat < 0; n++) begin
            @(negedge clk);
            if (ready) begin lat = n; r = result; end
        end
        checks++; if (lat !== 33) begin errors++; $display("FAIL midreset_restart_latency got %0d want 33", lat); end
        checks++; if (r !== model(1'b0, 32'd1000, 32'd7)) begin errors++; $display("FAIL midreset_result got %h want %h", r, model(1'b0, 32'd1000, 32'd7)); end
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_early_out();
        int lat, sc, want; logic [63:0] r, rh, ra; logic rd;
`ifdef DIV_EARLY_OUT_EN
        want = 1;
`else
        want = 33;
`endif
        run_op(1'b0, 32'd3, 32'd10, lat, sc, r, rh, ra, rd);
        checks++; if (lat !== want) begin errors++; $display("FAIL small_div_latency got %0d want %0d", lat, want); end
        checks++; if (r !== {32'd3, 32'd0}) begin errors++; $display("FAIL small_div_result got %h want %h", r, {32'd3, 32'd0}); end
        checks++; if (rh !== {32'd3, 32'd0}) begin errors++; $display("FAIL small_div_hold got %h want %h", rh, {32'd3, 32'd0}); end
        checks++; if (rd !== 1'b0 || ra !== 64'd0) begin errors++; $display("FAIL small_div_clear got rdy=%0b res=%h want 0/0", rd, ra); end
        run_op(1'b1, 32'hFFFF_FFFD, 32'd10, lat, sc, r, rh, ra, rd);
        checks++; if (r !== {32'hFFFF_FFFD, 32'd0} || lat !== want) begin errors++; $display("FAIL small_div_signed got lat=%0d res=%h want %0d/%h", lat, r, want, {32'hFFFF_FFFD, 32'd0}); end
    endtask

    task automatic test_random();
        int lat, sc; logic [63:0] r, rh, ra; logic rd;
        logic sgn; logic [31:0] a, b;
        for (int i = 0; i < 60; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: a = $urandom_range(0, 50);
                3: begin b = $urandom_range(1, 9); b = -b; end
                default: ;
            endcase
            run_op(sgn, a, b, lat, sc, r, rh, ra, rd);
            checks++; if (r !== model(sgn, a, b)) begin errors++; $display("FAIL rand_result_%0d s=%0b a=%h b=%h got %h want %h", i, sgn, a, b, r, model(sgn, a, b)); end
            checks++; if (lat !== exp_lat(sgn, a, b) || sc !== lat) begin errors++; $display("FAIL rand_timing_%0d got lat=%0d stall=%0d want %0d", i, lat, sc, exp_lat(sgn, a, b)); end
            checks++; if (rh !== r || ra !== 64'd0 || rd !== 1'b0) begin errors++; $display("FAIL rand_hold_clear_%0d got hold=%h after=%h rdy=%0b", i, rh, ra, rd); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_div_zero();
        test_annul();
        test_reset_mid();
        test_early_out();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
